retire_unit: RTL and testbench

- In-order retire buffer at the back of the execute pipeline. It is the consumer end of the result path that the fixed-latency bypass pipeline and the variable-latency units drive.
- Decode allocates a tagged slot per instruction, in program order.
- Results return tagged and possibly out of order.
- The block writes results back to the register file strictly in program order, one per cycle, and discards all in-flight work on a flush.

---
 rtl/retire_unit.sv | 120 ++++++++++++
 tb/tb_retire_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_unit.sv
// In-order retire buffer: tagged slot allocation, out-of-order result capture, in-order writeback.
// Optional RETIRE_COUNT_EN adds a 64-bit retired-instruction counter (instret).
module retire_unit #(
    parameter int DEPTH = 4,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic             issue_we,
    input  logic [4:0]       issue_rd,
    output logic [TAG_W-1:0] issue_tag,
    input  logic             result_valid,
    input  logic [TAG_W-1:0] result_tag,
    input  logic [31:0]      result_data,
    input  logic             flush,
    output logic             retire_valid,
    output logic             retire_we,
    output logic [4:0]       retire_rd,
    output logic [31:0]      retire_data,
`ifdef RETIRE_COUNT_EN
    output logic [63:0]      instret,
`endif
    output logic             tag_err
);

    logic [DEPTH-1:0] slot_valid;
    logic [DEPTH-1:0] slot_done;
    logic [DEPTH-1:0] slot_we;
    logic [4:0]       slot_rd   [DEPTH];
    logic [31:0]      slot_data [DEPTH];

    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [TAG_W:0]   count;

    logic alloc;
    logic retire_fire;
    logic result_ok;

    assign issue_ready = (count < (TAG_W+1)'(DEPTH));
    assign issue_tag   = tail;

    // Flush suppresses every other update in its cycle.
    assign alloc       = issue_valid && issue_ready && !flush;
    assign retire_fire = slot_valid[head] && slot_done[head] && !flush;
    assign result_ok   = slot_valid[result_tag] && !slot_done[result_tag];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_valid   <= '0;
            slot_done    <= '0;
            slot_we      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_rd[i]   <= '0;
                slot_data[i] <= '0;
            end
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            retire_valid <= 1'b0;
            retire_we    <= 1'b0;
            retire_rd    <= '0;
            retire_data  <= '0;
            tag_err      <= 1'b0;
        end else if (flush) begin
            slot_valid   <= '0;
            slot_done    <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            retire_valid <= 1'b0;
            retire_we    <= 1'b0;
        end else begin
            retire_valid <= retire_fire;
            retire_we    <= retire_fire && slot_we[head];
            if (retire_fire) begin
                retire_rd        <= slot_rd[head];
                retire_data      <= slot_data[head];
                slot_valid[head] <= 1'b0;
                head             <= head + TAG_W'(1);
            end

            // The slot retiring this edge is already done, so a result for it is an error.
            if (result_valid) begin
                if (result_ok) begin
                    slot_data[result_tag] <= result_data;
                    slot_done[result_tag] <= 1'b1;
                end else begin
                    tag_err <= 1'b1;
                end
            end

            if (alloc) begin
                slot_valid[tail] <= 1'b1;
                slot_done[tail]  <= 1'b0;
                slot_we[tail]    <= issue_we && (issue_rd != 5'd0);
                slot_rd[tail]    <= issue_rd;
                tail             <= tail + TAG_W'(1);
            end

            if (alloc && !retire_fire)
                count <= count + (TAG_W+1)'(1);
            else if (!alloc && retire_fire)
                count <= count - (TAG_W+1)'(1);
        end
    end

`ifdef RETIRE_COUNT_EN
    // Survives flush; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            instret <= '0;
        else if (retire_fire)
            instret <= instret + 64'd1;
    end
`endif

endmodule

// File: tb/tb_retire_unit.sv
// Scoreboard testbench for retire_unit: stimulus pushes expected retires, a monitor pops on retire_valid.
module tb_retire_unit;

    localparam int DEPTH = 4;
    localparam int TAG_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             issue_valid;
    logic             issue_ready;
    logic             issue_we;
    logic [4:0]       issue_rd;
    logic [TAG_W-1:0] issue_tag;
    logic             result_valid;
    logic [TAG_W-1:0] result_tag;
    logic [31:0]      result_data;
    logic             flush;
    logic             retire_valid;
    logic             retire_we;
    logic [4:0]       retire_rd;
    logic [31:0]      retire_data;
    logic             tag_err;
`ifdef RETIRE_COUNT_EN
    logic [63:0]      instret;
`endif

    retire_unit #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_we     (issue_we),
        .issue_rd     (issue_rd),
        .issue_tag    (issue_tag),
        .result_valid (result_valid),
        .result_tag   (result_tag),
        .result_data  (result_data),
        .flush        (flush),
        .retire_valid (retire_valid),
        .retire_we    (retire_we),
        .retire_rd    (retire_rd),
        .retire_data  (retire_data),
`ifdef RETIRE_COUNT_EN
        .instret      (instret),
`endif
        .tag_err      (tag_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Allocates one slot; when keep is set the instruction is expected to retire with (exp_we, rd, data).
    task automatic issue(input logic we, input logic [4:0] rd, input logic [TAG_W-1:0] exp_tag,
                         input logic keep, input logic exp_we, input logic [31:0] data);
        exp_t e;
        chk("issue_tag", 64'(issue_tag), 64'(exp_tag));
        issue_valid = 1'b1;
        issue_we    = we;
        issue_rd    = rd;
        if (keep) begin
            e.we = exp_we; e.rd = rd; e.data = data;
            exp_q.push_back(e);
        end
        tick();
        issue_valid = 1'b0;
        issue_we    = 1'b0;
        issue_rd    = 5'd0;
    endtask

    task automatic res(input logic [TAG_W-1:0] tag, input logic [31:0] data);
        result_valid = 1'b1;
        result_tag   = tag;
        result_data  = data;
        tick();
        result_valid = 1'b0;
    endtask

    // Monitor: every retire must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && retire_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_retire: got rd=%0d data=%0h expected no retire", retire_rd, retire_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("retire", 64'({retire_we, retire_rd, retire_data}), 64'({e.we, e.rd, e.data}));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; issue_valid = 0; issue_we = 0; issue_rd = 0;
        result_valid = 0; result_tag = 0; result_data = 0; flush = 0;
        idle(2);
        chk("rst_retire_valid", 64'(retire_valid), 64'd0);
        chk("rst_issue_ready",  64'(issue_ready),  64'd1);
        chk("rst_issue_tag",    64'(issue_tag),    64'd0);
        chk("rst_tag_err",      64'(tag_err),      64'd0);
        chk("rst_retire_data",  64'(retire_data),  64'd0);
        reset = 1'b0;
        tick();

        // In-order results; first retire two edges after result 0.
        issue(1, 5'd5, 2'd0, 1, 1, 32'h11);
        issue(1, 5'd6, 2'd1, 1, 1, 32'h22);
        issue(1, 5'd7, 2'd2, 1, 1, 32'h33);
        res(2'd0, 32'h11);
        chk("lat_edge_n", 64'(retire_valid), 64'd0);
        res(2'd1, 32'h22);
        chk("lat_edge_n1", 64'(retire_valid), 64'd1);
        res(2'd2, 32'h33);
        idle(5);
        chk("inorder_drain", 64'(exp_q.size()), 64'd0);

        // Out-of-order completion.
        do_reset();
        for (int i = 0; i < 4; i++)
            issue(1, 5'(i + 1), 2'(i), 1, 1, 32'hA0 + 32'(i));
        chk("ooo_full_ready", 64'(issue_ready), 64'd0);
        res(2'd3, 32'hA3); chk("ooo_hold3", 64'(retire_valid), 64'd0);
        res(2'd2, 32'hA2); chk("ooo_hold2", 64'(retire_valid), 64'd0);
        res(2'd1, 32'hA1); chk("ooo_hold1", 64'(retire_valid), 64'd0);
        res(2'd0, 32'hA0); chk("ooo_hold0", 64'(retire_valid), 64'd0);
        tick();            chk("ooo_first", 64'(retire_data), 64'hA0);
        tick();            chk("ooo_b2b",   64'(retire_valid), 64'd1);
        idle(5);
        chk("ooo_drain", 64'(exp_q.size()), 64'd0);

        // Full / wrap: ten allocations across the wrap.
        do_reset();
        for (int i = 0; i < 4; i++)
            issue(1, 5'(10 + i), 2'(i), 1, 1, 32'h100 + 32'(i));
        chk("wrap_full_ready", 64'(issue_ready), 64'd0);
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd31;
        res(2'd0, 32'h100);
        tick();
        issue_valid = 1'b0; issue_we = 1'b0; issue_rd = 5'd0;
        chk("wrap_ready_after_retire", 64'(issue_ready), 64'd1);
        for (int i = 4; i < 10; i++) begin
            issue(1, 5'(10 + i), 2'(i % 4), 1, 1, 32'h100 + 32'(i));
            chk("wrap_full_again", 64'(issue_ready), 64'd0);
            res(2'((i - 3) % 4), 32'h100 + 32'(i - 3));
            tick();
        end
        res(2'd3, 32'h107);
        res(2'd0, 32'h108);
        res(2'd1, 32'h109);
        idle(5);
        chk("wrap_drain", 64'(exp_q.size()), 64'd0);
`ifdef RETIRE_COUNT_EN
        chk("instret_10", instret, 64'd10);
`endif

        // rd=0 and no-write instructions retire without a write enable.
        do_reset();
        issue(1, 5'd0, 2'd0, 1, 0, 32'h55);
        issue(0, 5'd9, 2'd1, 1, 0, 32'h66);
        res(2'd0, 32'h55);
        res(2'd1, 32'h66);
        idle(4);
        chk("nowrite_drain", 64'(exp_q.size()), 64'd0);

        // Flush with concurrent issue and result.
        do_reset();
        issue(1, 5'd1, 2'd0, 0, 1, 32'h0);
        issue(1, 5'd2, 2'd1, 0, 1, 32'h0);
        issue(1, 5'd3, 2'd2, 0, 1, 32'h0);
        res(2'd1, 32'hBB);
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd4;
        result_valid = 1'b1; result_tag = 2'd0; result_data = 32'hCC;
        flush = 1'b1;
        tick();
        flush = 1'b0; issue_valid = 1'b0; result_valid = 1'b0;
        chk("flush_retire_valid", 64'(retire_valid), 64'd0);
        chk("flush_ready",        64'(issue_ready),  64'd1);
        chk("flush_tag",          64'(issue_tag),    64'd0);
        chk("flush_tag_err",      64'(tag_err),      64'd0);
        idle(4);
        issue(1, 5'd8, 2'd0, 1, 1, 32'hDD);
        res(2'd0, 32'hDD);
        idle(4);
        chk("flush_drain", 64'(exp_q.size()), 64'd0);

        // Tag error on a free slot, sticky.
        res(2'd2, 32'h1);
        chk("tag_err_set", 64'(tag_err), 64'd1);
        idle(3);
        chk("tag_err_sticky", 64'(tag_err), 64'd1);

        // Asynchronous reset mid-stream: pending result never retires.
        issue(1, 5'd12, 2'd1, 0, 1, 32'h0);
        issue(1, 5'd13, 2'd2, 0, 1, 32'h0);
        res(2'd1, 32'hEE);
        reset = 1'b1;
        #1;
        chk("mid_rst_retire_valid", 64'(retire_valid), 64'd0);
        chk("mid_rst_retire_we",    64'(retire_we),    64'd0);
        chk("mid_rst_retire_rd",    64'(retire_rd),    64'd0);
        chk("mid_rst_retire_data",  64'(retire_data),  64'd0);
        chk("mid_rst_tag_err",      64'(tag_err),      64'd0);
        chk("mid_rst_ready",        64'(issue_ready),  64'd1);
        chk("mid_rst_tag",          64'(issue_tag),    64'd0);
`ifdef RETIRE_COUNT_EN
        chk("mid_rst_instret",      instret,           64'd0);
`endif
        tick();
        reset = 1'b0;
        idle(5);
        chk("final_queue", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
